fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer in front of the combinational imem.
//   - Owns the PC and drives imem's address.
//   - Registers {pc, instruction} into an IF stage register with a valid flag.
//   - Handles pipeline stall and branch redirect.
//   - Detects the halt instruction and freezes fetch until redirected or reset.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   HALT_INSN   32'h0000_0063  halt encoding (beq x0,x0,0)
//   IMEM_WORDS  256            imem depth in words; used only for oor_o
// PORTS
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   stall_i        in   1   downstream not accepting; hold PC and IF register
//   redirect_i     in   1   branch/jump taken; load redirect_pc_i, flush IF
//   redirect_pc_i  in   32  redirect target
//   imem_addr_o    out  32  byte address to imem; equals pc_q (combinational)
//   imem_instr_i   in   32  imem read data (same cycle as imem_addr_o)
//   if_valid_o     out  1   IF register holds a live instruction
//   if_pc_o        out  32  PC of the IF instruction
//   if_instr_o     out  32  IF instruction
//   halted_o       out  1   FSM in HALT
//   misalign_o     out  1   sticky: a redirect target had bits[1:0] != 0
//   oor_o          out  1   sticky: pc_q reached >= IMEM_WORDS*4
//   fetch_count_o  out  32  instructions latched into IF; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//   Reset, while rst=1 at a rising edge:
//     - pc_q=RESET_PC, state=BOOT
//     - if_valid_o=0, if_pc_o=0, if_instr_o=0
//     - halted_o=0, misalign_o=0, oor_o=0, fetch_count_o=0
//   Reset overrides everything, including mid-stall and HALT.
//   FSM states: BOOT, RUN, HALT.
//     - BOOT: one idle cycle after reset, no latch. BOOT->RUN unconditionally.
//     - RUN, priority per edge: redirect_i > stall_i > normal fetch.
//     - HALT: halted_o=1, pc_q frozen, if_valid_o=0.
//       - stall_i is ignored.
//       - redirect_i -> RUN with pc_q=target. This squashes a speculatively fetched halt.
//   Redirect, in RUN or HALT:
//     - pc_q <= {redirect_pc_i[31:2], 2'b00}.
//     - if_valid_o <= 0. Wins over a simultaneous stall.
//     - If redirect_pc_i[1:0] != 0: set misalign_o.
//     - Nothing is latched that cycle; fetch_count_o is unchanged.
//   Stall, in RUN without redirect:
//     - pc_q, IF register, if_valid_o and fetch_count_o all hold.
//   Normal fetch, in RUN:
//     - if_pc_o <= pc_q; if_instr_o <= imem_instr_i; if_valid_o <= 1.
//     - fetch_count_o += 1, saturating.
//     - pc_q <= pc_q + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
//     - Latency: address presented in cycle N appears on the IF outputs after edge N+1.
//   Halt detect: on a normal fetch where imem_instr_i == HALT_INSN:
//     - The halt is latched into IF (valid=1) and counted.
//     - pc_q does NOT advance. Next state is HALT.
//     - if_valid_o drops to 0 on the following edge.
//   oor_o sets on any edge where the next pc_q >= IMEM_WORDS*4. It clears only on reset.
//   Only imem_instr_i is combinational from pc_q. All other outputs are registered.
// TESTING
//   1. Reset, imem = nop(0x13) x4 then 0x63:
//      - valid first high 2 edges after rst drops.
//      - if_pc 0,4,8,C,10; halted_o=1 after pc 0x10 latched.
//      - fetch_count=5; pc frozen at 0x10.
//   2. stall_i high 3 cycles while if_pc=8:
//      - IF register, if_pc=8, if_valid and fetch_count unchanged.
//      - Resume fetches pc 0xC.
//   3. redirect_i with stall_i in the same cycle, target 0x40:
//      - if_valid=0 next edge.
//      - The following edge latches if_pc=0x40.
//   4. In HALT, redirect to 0x20:
//      - Returns to RUN, halted_o=0.
//      - if_pc=0x20 one edge later.
//   5. redirect to 0x42:
//      - pc becomes 0x40, misalign_o=1 and stays 1.
//      - redirect to 0x3FC, run: oor_o=1 when pc=0x400.
//      - imem returns 0x63 -> HALT.
//   6. rst asserted mid-stream and in HALT:
//      - All outputs return to their reset values on the next edge; state=BOOT.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers {pc, instr} into the IF stage,
// and handles stall, branch redirect and halt detection.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN  = 32'h0000_0063,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        halted_o,
    output logic        misalign_o,
    output logic        oor_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_e;

    // 33 bits so the limit cannot wrap when compared against a 32-bit PC
    localparam logic [32:0] OOR_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misalign_q, misalign_d;
    logic        oor_q, oor_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] redirect_aligned;
    logic        redirect_misaligned;

    assign redirect_aligned    = {redirect_pc_i[31:2], 2'b00};
    assign redirect_misaligned = |redirect_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_instr_q    <= 32'h0;
            misalign_q    <= 1'b0;
            oor_q         <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            misalign_q    <= misalign_d;
            oor_q         <= oor_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    pc_d       = redirect_aligned;
                    if_valid_d = 1'b0;
                    misalign_d = misalign_q | redirect_misaligned;
                end else if (!stall_i) begin
                    if_pc_d       = pc_q;
                    if_instr_d    = imem_instr_i;
                    if_valid_d    = 1'b1;
                    fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                                     : fetch_count_q + 32'd1;
                    // A fetched halt parks the PC on itself until a redirect arrives
                    if (imem_instr_i == HALT_INSN) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                if_valid_d = 1'b0;
                if (redirect_i) begin
                    state_d    = ST_RUN;
                    pc_d       = redirect_aligned;
                    misalign_d = misalign_q | redirect_misaligned;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        oor_d = oor_q | ({1'b0, pc_d} >= OOR_LIMIT);
    end

    assign imem_addr_o   = pc_q;
    assign if_valid_o    = if_valid_q;
    assign if_pc_o       = if_pc_q;
    assign if_instr_o    = if_instr_q;
    assign halted_o      = (state_q == ST_HALT);
    assign misalign_o    = misalign_q;
    assign oor_o         = oor_q;
    assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl: directed stimulus pushes expected IF latches,
// a negedge monitor pops and compares each newly latched instruction.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0063;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        halted_o;
    logic        misalign_o;
    logic        oor_o;
    logic [31:0] fetch_count_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[256];
    int          n_vec  = 0;
    int          n_fail = 0;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_instr_i (imem_instr_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .halted_o     (halted_o),
        .misalign_o   (misalign_o),
        .oor_o        (oor_o),
        .fetch_count_o(fetch_count_o)
    );

    always #5 clk = ~clk;

    // Anything past the 1 KiB image reads back as the halt encoding
    assign imem_instr_i = (imem_addr_o < 32'h400) ? mem[imem_addr_o[9:2]] : HALT;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] cnt);
        exp_q.push_back('{pc: pc, instr: instr, cnt: cnt});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " valid"},    {31'b0, if_valid_o}, 32'h0);
        chk({tag, " if_pc"},    if_pc_o,             32'h0);
        chk({tag, " if_instr"}, if_instr_o,          32'h0);
        chk({tag, " halted"},   {31'b0, halted_o},   32'h0);
        chk({tag, " misalign"}, {31'b0, misalign_o}, 32'h0);
        chk({tag, " oor"},      {31'b0, oor_o},      32'h0);
        chk({tag, " count"},    fetch_count_o,       32'h0);
        chk({tag, " addr"},     imem_addr_o,         32'h0);
    endtask

    // Monitor: a new IF entry is a valid cycle whose {pc,instr} differs from the last sample
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    always @(negedge clk) begin
        if (if_valid_o && (!prev_v || if_pc_o != prev_pc || if_instr_o != prev_instr)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected latch: got pc %h instr %h, expected none", if_pc_o, if_instr_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb if_pc",    if_pc_o,       e.pc);
                chk("sb if_instr", if_instr_o,    e.instr);
                chk("sb count",    fetch_count_o, e.cnt);
            end
        end
        prev_v     = if_valid_o;
        prev_pc    = if_pc_o;
        prev_instr = if_instr_o;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[4] = HALT;  // address 0x10
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        step(2);
        check_reset("reset");

        // 1: boot, four nops then halt at 0x10
        push(32'h0, NOP, 1); push(32'h4, NOP, 2); push(32'h8, NOP, 3);
        push(32'hC, NOP, 4); push(32'h10, HALT, 5);
        rst = 1'b0;
        step(1);
        chk("boot valid", {31'b0, if_valid_o}, 32'h0);
        step(1);
        chk("first valid", {31'b0, if_valid_o}, 32'h1);
        chk("first if_pc", if_pc_o, 32'h0);
        step(4);
        chk("halt halted", {31'b0, halted_o}, 32'h1);
        chk("halt count",  fetch_count_o, 32'd5);
        chk("halt valid",  {31'b0, if_valid_o}, 32'h1);
        chk("halt addr",   imem_addr_o, 32'h10);
        stall_i = 1'b1;
        step(1);
        chk("halt2 valid",  {31'b0, if_valid_o}, 32'h0);
        chk("halt2 halted", {31'b0, halted_o}, 32'h1);
        chk("halt2 addr",   imem_addr_o, 32'h10);
        stall_i = 1'b0;

        // 4: redirect out of HALT to 0x20
        push(32'h20, NOP, 6);
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        step(1);
        chk("unhalt halted", {31'b0, halted_o}, 32'h0);
        chk("unhalt valid",  {31'b0, if_valid_o}, 32'h0);
        chk("unhalt addr",   imem_addr_o, 32'h20);
        chk("unhalt count",  fetch_count_o, 32'd5);
        redirect_i = 1'b0;
        step(1);
        chk("unhalt if_pc", if_pc_o, 32'h20);

        // 2: refetch from 0, stall 3 cycles while if_pc=8
        push(32'h0, NOP, 7); push(32'h4, NOP, 8); push(32'h8, NOP, 9); push(32'hC, NOP, 10);
        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        step(1);
        chk("redir0 valid", {31'b0, if_valid_o}, 32'h0);
        redirect_i = 1'b0;
        step(3);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall if_pc", if_pc_o, 32'h8);
            chk("stall valid", {31'b0, if_valid_o}, 32'h1);
            chk("stall count", fetch_count_o, 32'd9);
            chk("stall addr",  imem_addr_o, 32'hC);
        end
        stall_i = 1'b0;
        step(1);
        chk("resume if_pc", if_pc_o, 32'hC);
        chk("resume count", fetch_count_o, 32'd10);

        // 3: redirect and stall together, target 0x40
        push(32'h40, NOP, 11);
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        step(1);
        chk("rs valid", {31'b0, if_valid_o}, 32'h0);
        chk("rs addr",  imem_addr_o, 32'h40);
        chk("rs count", fetch_count_o, 32'd10);
        redirect_i = 1'b0; stall_i = 1'b0;
        step(1);
        chk("rs if_pc", if_pc_o, 32'h40);

        // 5: misaligned redirect, then run off the end of imem into a halt
        push(32'h3FC, NOP, 12); push(32'h400, HALT, 13);
        redirect_i = 1'b1; redirect_pc_i = 32'h42;
        step(1);
        chk("mis addr",     imem_addr_o, 32'h40);
        chk("mis misalign", {31'b0, misalign_o}, 32'h1);
        chk("mis valid",    {31'b0, if_valid_o}, 32'h0);
        redirect_pc_i = 32'h3FC;
        step(1);
        chk("edge addr",     imem_addr_o, 32'h3FC);
        chk("edge misalign", {31'b0, misalign_o}, 32'h1);
        chk("edge oor",      {31'b0, oor_o}, 32'h0);
        redirect_i = 1'b0;
        step(1);
        chk("oor oor",   {31'b0, oor_o}, 32'h1);
        chk("oor addr",  imem_addr_o, 32'h400);
        step(1);
        chk("oor halted",   {31'b0, halted_o}, 32'h1);
        chk("oor addr2",    imem_addr_o, 32'h400);
        chk("oor count",    fetch_count_o, 32'd13);
        chk("oor sticky",   {31'b0, oor_o}, 32'h1);
        chk("mis sticky",   {31'b0, misalign_o}, 32'h1);

        // 6: reset in HALT, then reset mid-stream under stall
        rst = 1'b1;
        step(1);
        check_reset("rst halt");
        rst = 1'b0;
        push(32'h0, NOP, 1); push(32'h4, NOP, 2);
        step(3);
        chk("rerun count", fetch_count_o, 32'd2);
        chk("rerun if_pc", if_pc_o, 32'h4);
        stall_i = 1'b1; rst = 1'b1;
        step(1);
        check_reset("rst mid");
        stall_i = 1'b0;
        step(1);
        chk("sb drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
